// File: rtl/confreg_resp.sv
// Memory-mapped config responder: scratch regs, LED, synchronized switches, timer/compare with IRQ.
// Optional access counter at 0x38 enabled by defining CONFREG_PERF_EN.
module confreg_resp #(
    parameter logic [15:0] LED_RESET   = 16'h0000,
    parameter logic [31:0] CMP_RESET   = 32'hFFFF_FFFF,
    parameter logic [31:0] TIMER_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        conf_en,
    input  logic [3:0]  conf_wen,
    input  logic [31:0] conf_addr,
    input  logic [31:0] conf_wdata,
    output logic [31:0] conf_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic        timer_irq
);

    localparam logic [5:0] W_LED    = 6'h08;
    localparam logic [5:0] W_SWITCH = 6'h09;
    localparam logic [5:0] W_TIMER  = 6'h0A;
    localparam logic [5:0] W_CMP    = 6'h0B;
    localparam logic [5:0] W_STATUS = 6'h0C;
    localparam logic [5:0] W_CTRL   = 6'h0D;
    localparam logic [5:0] W_ACC    = 6'h0E;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  wen);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0] cr_q [8];
    logic [31:0] cr_d [8];
    logic [15:0] led_q, led_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] cmp_q, cmp_d;
    logic        match_q, match_d;
    logic        irq_en_q, irq_en_d;
    logic [7:0]  sw_meta_q, sw_sync_q;
    logic [31:0] rdata_q, rdata_d;
`ifdef CONFREG_PERF_EN
    logic [31:0] acc_q, acc_d;
`endif

    logic [5:0]  word_s;
    logic        rd_s;
    logic        wr_s;
    logic [31:0] led_merge_s;
    logic [31:0] ctrl_merge_s;

    assign word_s    = conf_addr[7:2];
    assign rd_s      = conf_en && (conf_wen == 4'b0000);
    assign wr_s      = conf_en && (conf_wen != 4'b0000);
    assign led       = led_q;
    assign timer_irq = match_q & irq_en_q;
    assign conf_rdata = rdata_q;

    // Next-state for all registers: byte-lane writes, timer increment, sticky match, read mux
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            cr_d[i] = cr_q[i];
        end
        led_d        = led_q;
        timer_d      = timer_q + 32'd1;
        cmp_d        = cmp_q;
        match_d      = match_q;
        irq_en_d     = irq_en_q;
        rdata_d      = rdata_q;
        led_merge_s  = merge_bytes({16'h0000, led_q}, conf_wdata, conf_wen);
        ctrl_merge_s = merge_bytes({31'h0, irq_en_q}, conf_wdata, conf_wen);
`ifdef CONFREG_PERF_EN
        acc_d = acc_q;
        if (conf_en && (acc_q != 32'hFFFF_FFFF)) begin
            acc_d = acc_q + 32'd1;
        end else begin
            acc_d = acc_q;
        end
`endif
        if (wr_s) begin
            case (word_s)
                6'h00, 6'h01, 6'h02, 6'h03,
                6'h04, 6'h05, 6'h06, 6'h07:
                    cr_d[word_s[2:0]] = merge_bytes(cr_q[word_s[2:0]], conf_wdata, conf_wen);
                W_LED:    led_d    = led_merge_s[15:0];
                // Unwritten timer lanes keep counting; written lanes take wdata
                W_TIMER:  timer_d  = merge_bytes(timer_q + 32'd1, conf_wdata, conf_wen);
                W_CMP:    cmp_d    = merge_bytes(cmp_q, conf_wdata, conf_wen);
                W_STATUS: begin
                    if (conf_wen[0] && conf_wdata[0]) begin
                        match_d = 1'b0;
                    end else begin
                        match_d = match_q;
                    end
                end
                W_CTRL:   irq_en_d = ctrl_merge_s[0];
`ifdef CONFREG_PERF_EN
                W_ACC:    acc_d    = 32'h0000_0000;
`endif
                default: ;
            endcase
        end else begin
            cr_d[0] = cr_q[0];
        end
        // Set has priority over a same-cycle W1C
        if (timer_q == cmp_q) begin
            match_d = 1'b1;
        end else begin
            match_d = match_d;
        end
        if (rd_s) begin
            case (word_s)
                6'h00, 6'h01, 6'h02, 6'h03,
                6'h04, 6'h05, 6'h06, 6'h07:
                          rdata_d = cr_q[word_s[2:0]];
                W_LED:    rdata_d = {16'h0000, led_q};
                W_SWITCH: rdata_d = {24'h00_0000, sw_sync_q};
                W_TIMER:  rdata_d = timer_q;
                W_CMP:    rdata_d = cmp_q;
                W_STATUS: rdata_d = {31'h0, match_q};
                W_CTRL:   rdata_d = {31'h0, irq_en_q};
`ifdef CONFREG_PERF_EN
                W_ACC:    rdata_d = acc_q;
`endif
                default:  rdata_d = 32'h0000_0000;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) begin
                cr_q[i] <= 32'h0000_0000;
            end
            led_q     <= LED_RESET;
            timer_q   <= TIMER_RESET;
            cmp_q     <= CMP_RESET;
            match_q   <= 1'b0;
            irq_en_q  <= 1'b0;
            sw_meta_q <= 8'h00;
            sw_sync_q <= 8'h00;
            rdata_q   <= 32'h0000_0000;
`ifdef CONFREG_PERF_EN
            acc_q     <= 32'h0000_0000;
`endif
        end else begin
            for (int i = 0; i < 8; i++) begin
                cr_q[i] <= cr_d[i];
            end
            led_q     <= led_d;
            timer_q   <= timer_d;
            cmp_q     <= cmp_d;
            match_q   <= match_d;
            irq_en_q  <= irq_en_d;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
            rdata_q   <= rdata_d;
`ifdef CONFREG_PERF_EN
            acc_q     <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_confreg_resp.sv
// Bench for confreg_resp: vector table, directed corner sequences, randomized traffic vs. a register-map model.
module tb_confreg_resp;

    logic        clk = 1'b0;
    logic        resetn;
    logic        conf_en;
    logic [3:0]  conf_wen;
    logic [31:0] conf_addr;
    logic [31:0] conf_wdata;
    logic [31:0] conf_rdata;
    logic [7:0]  switch;
    logic [15:0] led;
    logic        timer_irq;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    confreg_resp dut (
        .clk(clk), .resetn(resetn), .conf_en(conf_en), .conf_wen(conf_wen),
        .conf_addr(conf_addr), .conf_wdata(conf_wdata), .conf_rdata(conf_rdata),
        .switch(switch), .led(led), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    // Reference model of the register map
    logic [31:0] m_cr [8];
    logic [15:0] m_led;
    logic [31:0] m_timer, m_cmp, m_rdata, m_acc;
    logic        m_match, m_irqen;
    logic [7:0]  sw_hist [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] d,
                                          input logic [3:0] wen);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (wen[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int w);
        if (w < 8) return m_cr[w];
        if (w == 8) return {16'h0, m_led};
        if (w == 9) return (sw_hist.size() >= 2) ? {24'h0, sw_hist[sw_hist.size()-2]} : 32'h0;
        if (w == 10) return m_timer;
        if (w == 11) return m_cmp;
        if (w == 12) return {31'h0, m_match};
        if (w == 13) return {31'h0, m_irqen};
`ifdef CONFREG_PERF_EN
        if (w == 14) return m_acc;
`endif
        return 32'h0;
    endfunction

    task automatic model_edge(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                              input logic [31:0] wd);
        int w;
        logic hit;
        logic [31:0] nt, tmp;
        w = int'(addr[7:2]);
        if (!resetn) begin
            for (int i = 0; i < 8; i++) m_cr[i] = 32'h0;
            m_led = 16'h0000; m_timer = 32'h0; m_cmp = 32'hFFFF_FFFF;
            m_match = 1'b0; m_irqen = 1'b0; m_rdata = 32'h0; m_acc = 32'h0;
            sw_hist.delete();
        end else begin
            hit = (m_timer == m_cmp);
            if (en && wen == 4'h0) m_rdata = m_read(w);
            nt = m_timer + 32'd1;
            if (en && wen != 4'h0) begin
                if (w < 8) m_cr[w] = lanes(m_cr[w], wd, wen);
                else if (w == 8) begin tmp = lanes({16'h0, m_led}, wd, wen); m_led = tmp[15:0]; end
                else if (w == 10) nt = lanes(nt, wd, wen);
                else if (w == 11) m_cmp = lanes(m_cmp, wd, wen);
                else if (w == 12) begin if (wen[0] && wd[0]) m_match = 1'b0; end
                else if (w == 13) begin tmp = lanes({31'h0, m_irqen}, wd, wen); m_irqen = tmp[0]; end
            end
            if (hit) m_match = 1'b1;
            m_timer = nt;
`ifdef CONFREG_PERF_EN
            if (en && wen != 4'h0 && w == 14) m_acc = 32'h0;
            else if (en && m_acc != 32'hFFFF_FFFF) m_acc = m_acc + 32'd1;
`endif
            sw_hist.push_back(switch);
            if (sw_hist.size() > 4) void'(sw_hist.pop_front());
        end
    endtask

    // One bus cycle: drive, clock, update model, compare all outputs
    task automatic cyc(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wd);
        conf_en = en; conf_wen = wen; conf_addr = addr; conf_wdata = wd;
        @(posedge clk);
        model_edge(en, wen, addr, wd);
        #1;
        chk("rdata", conf_rdata, m_rdata);
        chk("led", {16'h0, led}, {16'h0, m_led});
        chk("irq", {31'h0, timer_irq}, {31'h0, (m_match & m_irqen)});
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          do_chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b1, 4'hF, 32'h0000_000C, 32'hAABB_CCDD, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 4'h4, 32'h0000_000C, 32'h0011_0000, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 4'h0, 32'h0000_000C, 32'h0,         1'b1, 32'hAA11_CCDD};
        tbl[3]  = '{1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 1'b1, 32'hAA11_CCDD};
        tbl[4]  = '{1'b1, 4'h0, 32'hFFFF_FF0F, 32'h0,         1'b1, 32'hAA11_CCDD};
        tbl[5]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         1'b1, 32'h1234_5678};
        tbl[6]  = '{1'b1, 4'hF, 32'h0000_003C, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 4'h0, 32'h0000_003C, 32'h0,         1'b1, 32'h0};
        tbl[8]  = '{1'b1, 4'hF, 32'h0000_0020, 32'hFFFF_1234, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 4'h0, 32'h0000_0020, 32'h0,         1'b1, 32'h0000_1234};
        tbl[10] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_1234};
        tbl[11] = '{1'b1, 4'hF, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'h0000_1234};

        resetn = 1'b0; switch = 8'h00;
        idle(); idle();
        chk("reset_rdata", conf_rdata, 32'h0);
        chk("reset_led", {16'h0, led}, 32'h0);
        chk("reset_irq", {31'h0, timer_irq}, 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].en, tbl[i].wen, tbl[i].addr, tbl[i].wdata);
            if (tbl[i].do_chk) chk($sformatf("vec%0d", i), conf_rdata, tbl[i].exp);
        end

        // Timer wrap
        cyc(1'b1, 4'hF, 32'h28, 32'hFFFF_FFFE);
        idle();
        cyc(1'b1, 4'h0, 32'h28, 32'h0); chk("wrap_ff", conf_rdata, 32'hFFFF_FFFF);
        cyc(1'b1, 4'h0, 32'h28, 32'h0); chk("wrap_0", conf_rdata, 32'h0000_0000);
        // Partial timer write: low lane from wdata, upper lanes from incremented value
        cyc(1'b1, 4'hF, 32'h28, 32'h0000_01FD);
        idle(); idle();
        cyc(1'b1, 4'h1, 32'h28, 32'h0000_0055);
        cyc(1'b1, 4'h0, 32'h28, 32'h0); chk("timer_part", conf_rdata, 32'h0000_0255);

        // Compare / irq
        cyc(1'b1, 4'hF, 32'h2C, 32'h0000_0100);
        cyc(1'b1, 4'hF, 32'h34, 32'h0000_0001);
        cyc(1'b1, 4'hF, 32'h28, 32'h0000_00F0);
        cyc(1'b1, 4'h1, 32'h30, 32'h0000_0001);
        chk("irq_cleared", {31'h0, timer_irq}, 32'h0);
        for (int i = 0; i < 15; i++) idle();
        chk("irq_before", {31'h0, timer_irq}, 32'h0);
        cyc(1'b1, 4'h0, 32'h28, 32'h0);
        chk("match_tmr", conf_rdata, 32'h0000_0100);
        chk("irq_rise", {31'h0, timer_irq}, 32'h1);
        for (int i = 0; i < 5; i++) idle();
        cyc(1'b1, 4'h0, 32'h30, 32'h0);
        chk("status_sticky", conf_rdata, 32'h1);
        chk("irq_sticky", {31'h0, timer_irq}, 32'h1);
        cyc(1'b1, 4'h1, 32'h30, 32'h0000_0001);
        chk("w1c", {31'h0, timer_irq}, 32'h0);
        cyc(1'b1, 4'hF, 32'h28, 32'h0000_00FE);
        idle(); idle();
        cyc(1'b1, 4'h1, 32'h30, 32'h0000_0001);
        chk("set_wins", {31'h0, timer_irq}, 32'h1);
        cyc(1'b1, 4'h1, 32'h30, 32'h0000_0001);
        chk("w1c2", {31'h0, timer_irq}, 32'h0);

        // Switch synchronizer
        switch = 8'hA5;
        cyc(1'b1, 4'h0, 32'h24, 32'h0); chk("sw_lat1", conf_rdata, 32'h0);
        cyc(1'b1, 4'h0, 32'h24, 32'h0); chk("sw_lat2", conf_rdata, 32'h0);
        cyc(1'b1, 4'h0, 32'h24, 32'h0); chk("sw_val", conf_rdata, 32'h0000_00A5);

        // Reset discards an in-flight read
        cyc(1'b1, 4'hF, 32'h00, 32'h0000_1234);
        cyc(1'b1, 4'h0, 32'h00, 32'h0); chk("cr0_pre", conf_rdata, 32'h0000_1234);
        resetn = 1'b0;
        idle();
        chk("rst_rdata", conf_rdata, 32'h0);
        chk("rst_led", {16'h0, led}, 32'h0);
        resetn = 1'b1;
        cyc(1'b1, 4'h0, 32'h00, 32'h0); chk("cr0_post", conf_rdata, 32'h0);

`ifdef CONFREG_PERF_EN
        cyc(1'b1, 4'h0, 32'h04, 32'h0);
        cyc(1'b1, 4'hF, 32'h08, 32'h1);
        cyc(1'b1, 4'h0, 32'h40, 32'h0);
        idle();
        cyc(1'b1, 4'h0, 32'h20, 32'h0);
        cyc(1'b1, 4'h1, 32'h3C, 32'h0);
        cyc(1'b1, 4'h0, 32'h38, 32'h0); chk("acc5", conf_rdata, 32'd5);
        cyc(1'b1, 4'hF, 32'h38, 32'h0);
        cyc(1'b1, 4'h0, 32'h38, 32'h0); chk("acc_clr", conf_rdata, 32'd0);
`else
        cyc(1'b1, 4'h0, 32'h38, 32'h0); chk("acc_unmapped", conf_rdata, 32'd0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r, d, a;
            logic [7:0]  off;
            logic [3:0]  wen;
            int idx;
            r = $urandom();
            idx = $urandom_range(0, 17);
            off = (idx < 16) ? 8'(idx * 4) : ((idx == 16) ? 8'h40 : 8'hFC);
            a = {r[31:8], off[7:2], r[1:0]};
            d = $urandom();
            if (off == 8'h2C && $urandom_range(0, 1) == 1) d = m_timer + 32'd3;
            wen = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) switch = 8'($urandom());
            resetn = ($urandom_range(0, 49) != 0);
            cyc($urandom_range(0, 3) != 0, wen, a, d);
        end
        resetn = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
